register_file: RTL and testbench

Parametrised multi-entry successor to the single load-enabled register in the VeriRISC datapath. It holds 2**ADDR_WIDTH words of WIDTH bits and provides one synchronous write port and two independent asynchronous read ports. It supports an optional hardwired-zero entry 0, optional write-to-read bypass, and a synchronous bulk clear. It feeds the ALU operand paths and takes the accumulator/result writeback.

---
 rtl/register_file_if.sv | 25 ++
 rtl/register_file.sv | 72 +++++++
 tb/tb_register_file.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register-file access bundle: one write port and two read ports.
// The datapath drives through master; the storage array sits behind slave.
interface register_file_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  clear;
  logic                  load;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      data_in;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [WIDTH-1:0]      data_out_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [WIDTH-1:0]      data_out_b;

  modport master (
    output clear, load, waddr, data_in, raddr_a, raddr_b,
    input  data_out_a, data_out_b
  );

  modport slave (
    input  clear, load, waddr, data_in, raddr_a, raddr_b,
    output data_out_a, data_out_b
  );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x WIDTH register file: one synchronous write port, two
// combinational read ports, optional hardwired-zero entry 0 and write bypass.
module register_file_rd_port #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic [(1<<ADDR_WIDTH)-1:0][WIDTH-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]                 raddr,
  input  logic [ADDR_WIDTH-1:0]                 waddr,
  input  logic                                  byp_en,
  input  logic [WIDTH-1:0]                      wdata,
  output logic [WIDTH-1:0]                      rdata
);
  // Zero entry wins over bypass so entry 0 never leaks write data.
  always_comb begin
    rdata = mem[raddr];
    if (byp_en && (raddr == waddr)) rdata = wdata;
    if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
  end
endmodule

module register_file #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 0
) (
  input logic               clk,
  input logic               rst,
  register_file_if.slave    bus
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][WIDTH-1:0]          mem;
  logic                                 wr_ok;
  logic                                 wr_en;
  logic                                 byp_en;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]      rdata;

  // A write is live only when neither reset nor clear is claiming the edge.
  assign wr_ok  = bus.load && !rst && !bus.clear;
  assign wr_en  = wr_ok && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign byp_en = (BYPASS != 0) && wr_ok;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) mem <= '0;
    else if (wr_en)       mem[bus.waddr] <= bus.data_in;
  end

  assign raddr[0]       = bus.raddr_a;
  assign raddr[1]       = bus.raddr_b;
  assign bus.data_out_a = rdata[0];
  assign bus.data_out_b = rdata[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    register_file_rd_port #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .mem    (mem),
      .raddr  (raddr[p]),
      .waddr  (bus.waddr),
      .byp_en (byp_en),
      .wdata  (bus.data_in),
      .rdata  (rdata[p])
    );
  end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: four 8x8 variants (ZERO_REG x BYPASS) share stimulus,
// plus one 16x16 bypassing instance; all checked against an array model.
module tb_register_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit group stimulus, shared by all four variants
  logic       clear8 = 1'b0, load8 = 1'b0;
  logic [2:0] waddr8 = '0, ra8 = '0, rb8 = '0;
  logic [7:0] din8 = '0;
  logic [7:0] out_a [4];
  logic [7:0] out_b [4];

  // 16-bit instance stimulus
  logic        clear16 = 1'b0, load16 = 1'b0;
  logic [3:0]  waddr16 = '0, ra16 = '0, rb16 = '0;
  logic [15:0] din16 = '0;
  logic [15:0] out16_a, out16_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Variant d: ZERO_REG = (d >= 2), BYPASS = d odd
  for (genvar g = 0; g < 4; g++) begin : g_dut
    register_file_if #(.WIDTH(8), .ADDR_WIDTH(3)) bus_i ();
    assign bus_i.clear   = clear8;
    assign bus_i.load    = load8;
    assign bus_i.waddr   = waddr8;
    assign bus_i.data_in = din8;
    assign bus_i.raddr_a = ra8;
    assign bus_i.raddr_b = rb8;
    assign out_a[g]      = bus_i.data_out_a;
    assign out_b[g]      = bus_i.data_out_b;
    register_file #(
      .WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(g >= 2 ? 1 : 0), .BYPASS(g % 2)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
    );
  end

  register_file_if #(.WIDTH(16), .ADDR_WIDTH(4)) bus16 ();
  assign bus16.clear   = clear16;
  assign bus16.load    = load16;
  assign bus16.waddr   = waddr16;
  assign bus16.data_in = din16;
  assign bus16.raddr_a = ra16;
  assign bus16.raddr_b = rb16;
  assign out16_a       = bus16.data_out_a;
  assign out16_b       = bus16.data_out_b;
  register_file #(.WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(1)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Reference model: plain storage arrays plus the read rules
  logic [7:0]  m8  [4][8];
  logic [15:0] m16 [16];

  function automatic logic [7:0] exp8(int d, logic [2:0] a);
    if (d >= 2 && a == 3'd0) return 8'h00;
    if ((d % 2 == 1) && load8 && !rst && !clear8 && a == waddr8) return din8;
    return m8[d][a];
  endfunction

  function automatic logic [15:0] exp16(logic [3:0] a);
    if (load16 && !rst && !clear16 && a == waddr16) return din16;
    return m16[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (rst || clear8) begin
        for (int a = 0; a < 8; a++) m8[d][a] = 8'h00;
      end else if (load8 && !(d >= 2 && waddr8 == 3'd0)) begin
        m8[d][waddr8] = din8;
      end
    end
    if (rst || clear16) begin
      for (int a = 0; a < 16; a++) m16[a] = 16'h0000;
    end else if (load16) begin
      m16[waddr16] = din16;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Reset arrives together with a write; the write must be lost.
    rst = 1'b1; load8 = 1'b1; waddr8 = 3'd2; din8 = 8'hFF;
    load16 = 1'b1; waddr16 = 4'd4; din16 = 16'hFFFF;
    tick();
    rst = 1'b0; load8 = 1'b0; load16 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      ra8 = 3'(a); rb8 = 3'(7 - a);
      #1;
      for (int d = 0; d < 4; d++) begin
        n_chk += 2;
        if (out_a[d] !== 8'h00) begin
          n_fail++; $display("FAIL reset_a dut%0d addr %0d: got %h want 00", d, a, out_a[d]);
        end
        if (out_b[d] !== 8'h00) begin
          n_fail++; $display("FAIL reset_b dut%0d addr %0d: got %h want 00", d, 7 - a, out_b[d]);
        end
      end
    end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      ra16 = 4'(a); rb16 = 4'(15 - a);
      #1;
      n_chk += 2;
      if (out16_a !== 16'h0000 || out16_b !== 16'h0000) begin
        n_fail++; $display("FAIL reset_w16 addr %0d: got %h/%h want 0000", a, out16_a, out16_b);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    for (int i = 1; i < 8; i++) begin
      load8 = 1'b1; waddr8 = 3'(i); din8 = 8'(8'h11 * i);
      tick();
    end
    load8 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      ra8 = 3'(a); rb8 = 3'(7 - a);
      #1;
      n_chk++;
      if (out_a[0] !== 8'(8'h11 * a)) begin
        n_fail++; $display("FAIL wr_const_a addr %0d: got %h want %h", a, out_a[0], 8'(8'h11 * a));
      end
      for (int d = 0; d < 4; d++) begin
        n_chk += 2;
        if (out_a[d] !== exp8(d, ra8)) begin
          n_fail++; $display("FAIL wr_a dut%0d addr %0d: got %h want %h", d, a, out_a[d], exp8(d, ra8));
        end
        if (out_b[d] !== exp8(d, rb8)) begin
          n_fail++; $display("FAIL wr_b dut%0d addr %0d: got %h want %h", d, 7 - a, out_b[d], exp8(d, rb8));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    load8 = 1'b1; waddr8 = 3'd3; din8 = 8'hAA; ra8 = 3'd3; rb8 = 3'd3;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (out_a[d] !== ((d % 2 == 1) ? 8'hAA : 8'h33)) begin
        n_fail++; $display("FAIL same_pre dut%0d: got %h want %h", d, out_a[d], (d % 2 == 1) ? 8'hAA : 8'h33);
      end
    end
    tick();
    load8 = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (out_a[d] !== 8'hAA) begin
        n_fail++; $display("FAIL same_post dut%0d: got %h want aa", d, out_a[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    load8 = 1'b1; waddr8 = 3'd0; din8 = 8'hFF; ra8 = 3'd0; rb8 = 3'd0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk += 2;
      if (out_a[d] !== exp8(d, 3'd0)) begin
        n_fail++; $display("FAIL zero_pre_a dut%0d: got %h want %h", d, out_a[d], exp8(d, 3'd0));
      end
      if (out_b[d] !== exp8(d, 3'd0)) begin
        n_fail++; $display("FAIL zero_pre_b dut%0d: got %h want %h", d, out_b[d], exp8(d, 3'd0));
      end
    end
    tick();
    load8 = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (out_a[d] !== ((d >= 2) ? 8'h00 : 8'hFF)) begin
        n_fail++; $display("FAIL zero_post dut%0d: got %h want %h", d, out_a[d], (d >= 2) ? 8'h00 : 8'hFF);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_clear_priority();
    logic [7:0] stored5;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 8; i++) begin
        load8 = 1'b1; waddr8 = 3'(i); din8 = 8'($urandom_range(1, 8'h59));
        tick();
      end
      stored5 = m8[1][5];
      clear8 = (mode == 0); rst = (mode == 1);
      load8 = 1'b1; waddr8 = 3'd5; din8 = 8'h5A; ra8 = 3'd5; rb8 = 3'd5;
      #1;
      n_chk++;
      if (out_b[1] !== stored5) begin
        n_fail++; $display("FAIL clr_nobyp mode%0d: got %h want %h", mode, out_b[1], stored5);
      end
      for (int d = 0; d < 4; d++) begin
        n_chk++;
        if (out_b[d] !== exp8(d, 3'd5)) begin
          n_fail++; $display("FAIL clr_pre_b mode%0d dut%0d: got %h want %h", mode, d, out_b[d], exp8(d, 3'd5));
        end
      end
      tick();
      clear8 = 1'b0; rst = 1'b0; load8 = 1'b0;
      for (int a = 0; a < 8; a++) begin
        @(negedge clk);
        ra8 = 3'(a); rb8 = 3'(7 - a);
        #1;
        for (int d = 0; d < 4; d++) begin
          n_chk++;
          if (out_a[d] !== 8'h00 || out_b[d] !== 8'h00) begin
            n_fail++; $display("FAIL clr_post mode%0d dut%0d addr %0d: got %h/%h want 00", mode, d, a, out_a[d], out_b[d]);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wide();
    load16 = 1'b1; waddr16 = 4'd15; din16 = 16'hFFFF;
    tick();
    waddr16 = 4'd8; din16 = 16'h8001; ra16 = 4'd8;
    #1;
    n_chk++;
    if (out16_a !== 16'h8001) begin
      n_fail++; $display("FAIL wide_byp: got %h want 8001", out16_a);
    end
    tick();
    load16 = 1'b0;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      ra16 = 4'(a); rb16 = 4'(15 - a);
      #1;
      n_chk += 2;
      if (out16_a !== ((a == 15) ? 16'hFFFF : (a == 8) ? 16'h8001 : 16'h0000)) begin
        n_fail++; $display("FAIL wide_a addr %0d: got %h", a, out16_a);
      end
      if (out16_b !== exp16(rb16)) begin
        n_fail++; $display("FAIL wide_b addr %0d: got %h want %h", 15 - a, out16_b, exp16(rb16));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      clear8  = ($urandom_range(0, 15) == 0);
      clear16 = ($urandom_range(0, 15) == 0);
      load8   = ($urandom_range(0, 3) != 0);
      load16  = ($urandom_range(0, 3) != 0);
      waddr8  = 3'($urandom);  din8  = 8'($urandom);
      waddr16 = 4'($urandom);  din16 = 16'($urandom);
      ra8  = ($urandom_range(0, 2) == 0) ? waddr8 : 3'($urandom);
      rb8  = 3'($urandom);
      ra16 = ($urandom_range(0, 2) == 0) ? waddr16 : 4'($urandom);
      rb16 = 4'($urandom);
      #1;
      for (int d = 0; d < 4; d++) begin
        n_chk += 2;
        if (out_a[d] !== exp8(d, ra8)) begin
          n_fail++; $display("FAIL rnd_a cyc%0d dut%0d addr %0d: got %h want %h", n, d, ra8, out_a[d], exp8(d, ra8));
        end
        if (out_b[d] !== exp8(d, rb8)) begin
          n_fail++; $display("FAIL rnd_b cyc%0d dut%0d addr %0d: got %h want %h", n, d, rb8, out_b[d], exp8(d, rb8));
        end
      end
      n_chk += 2;
      if (out16_a !== exp16(ra16) || out16_b !== exp16(rb16)) begin
        n_fail++; $display("FAIL rnd_w16 cyc%0d: got %h/%h want %h/%h", n, out16_a, out16_b, exp16(ra16), exp16(rb16));
      end
      tick();
    end
    rst = 1'b0; clear8 = 1'b0; clear16 = 1'b0; load8 = 1'b0; load16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_cycle();
    test_zero_reg();
    test_clear_priority();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
